// File: rtl/nand_share_arbiter.sv
// Round-robin arbiter that time-shares one 2-input NAND cell among NREQ requesters.
// Each accepted operation takes two cycles: grant/operand cycle, then result capture.
module nand_share_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] op_a,
    input  logic [NREQ-1:0] op_b,
    output logic [NREQ-1:0] gnt,
    output logic            nand_a,
    output logic            nand_b,
    input  logic            nand_y,
    output logic            y,
    output logic [IDW-1:0]  y_id,
    output logic            y_valid,
    output logic [7:0]      ops_done
);

    // Handshake: requester i raises req[i] with op_a[i]/op_b[i] stable; the
    // operation is accepted in the cycle gnt[i] is high, after which req[i]
    // must drop or carry a new operation by the edge that ends the gnt cycle.
    localparam logic IDLE = 1'b0;
    localparam logic EVAL = 1'b1;

    logic            state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  tag;
    logic [IDW-1:0]  win;
    logic [IDW-1:0]  idx;
    logic            found;
    logic [NREQ-1:0] win_oh;

    // Search starts at ptr and wraps naturally because NREQ is a power of two.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr + IDW'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        win_oh      = '0;
        win_oh[win] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            tag      <= '0;
            gnt      <= '0;
            nand_a   <= 1'b0;
            nand_b   <= 1'b0;
            y        <= 1'b0;
            y_id     <= '0;
            y_valid  <= 1'b0;
            ops_done <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    y_valid <= 1'b0;
                    if (found) begin
                        gnt    <= win_oh;
                        nand_a <= op_a[win];
                        nand_b <= op_b[win];
                        tag    <= win;
                        ptr    <= win + IDW'(1);
                        state  <= EVAL;
                    end
                end
                default: begin
                    y        <= nand_y;
                    y_id     <= tag;
                    y_valid  <= 1'b1;
                    ops_done <= ops_done + 8'd1;
                    gnt      <= '0;
                    nand_a   <= 1'b0;
                    nand_b   <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nand_share_arbiter.sv
// Scoreboard bench for nand_share_arbiter: requester agents, a transaction-level
// round-robin reference model feeding expected queues, and a negedge monitor.
module tb_nand_share_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] op_a = '0;
    logic [NREQ-1:0] op_b = '0;
    logic [NREQ-1:0] gnt;
    logic            nand_a;
    logic            nand_b;
    logic            nand_y;
    logic            y;
    logic [IDW-1:0]  y_id;
    logic            y_valid;
    logic [7:0]      ops_done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // grant entry: {cycle[15:0], gnt[3:0], a, b}
    logic [21:0] gq[$];
    // result entry: {cycle[15:0], y, id[1:0], ops[7:0]}
    logic [26:0] rq[$];
    logic [1:0]  opq[NREQ][$];

    int m_busy, m_ptr, m_cnt, m_w, m_j;
    logic [NREQ-1:0] m_oh;
    logic [15:0] c16;
    logic last_y;
    logic [IDW-1:0] last_id;
    logic [7:0] last_ops;

    nand_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
        .gnt(gnt), .nand_a(nand_a), .nand_b(nand_b), .nand_y(nand_y),
        .y(y), .y_id(y_id), .y_valid(y_valid), .ops_done(ops_done)
    );

    // the shared NAND cell
    assign nand_y = ~(nand_a & nand_b);

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Requester agents: drop req on grant, then present the next queued op.
    always @(negedge clk) begin
        if (rst) begin
            req = '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                logic [1:0] v;
                if (gnt[i]) req[i] = 1'b0;
                if (!req[i] && opq[i].size() > 0) begin
                    v = opq[i].pop_front();
                    op_a[i] = v[1];
                    op_b[i] = v[0];
                    req[i] = 1'b1;
                end
            end
        end
    end

    // Reference model: an operation starts whenever the shared cell is free
    // and someone requests; the winner is the first requester at or after ptr.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            gq.delete();
            rq.delete();
            m_busy = 0;
            m_ptr = 0;
            m_cnt = 0;
        end else begin
            cyc++;
            if (m_busy != 0) begin
                m_busy = 0;
            end else if (req != '0) begin
                m_w = -1;
                for (int k = 0; k < NREQ; k++) begin
                    m_j = (m_ptr + k) % NREQ;
                    if (m_w < 0 && req[m_j]) m_w = m_j;
                end
                m_cnt = (m_cnt + 1) % 256;
                m_oh = '0;
                m_oh[m_w] = 1'b1;
                c16 = cyc[15:0];
                gq.push_back({c16, m_oh, op_a[m_w], op_b[m_w]});
                c16 = c16 + 16'd1;
                rq.push_back({c16, ~(op_a[m_w] & op_b[m_w]), m_w[1:0], m_cnt[7:0]});
                m_ptr = (m_w + 1) % NREQ;
                m_busy = 1;
            end
        end
    end

    // Monitor: compare DUT outputs against the queue heads due this cycle.
    always @(negedge clk) begin
        logic [21:0] ge;
        logic [26:0] re;
        if (rst) begin
            last_y = 1'b0;
            last_id = '0;
            last_ops = 8'd0;
        end else begin
            if (gq.size() > 0 && gq[0][21:6] == cyc[15:0]) begin
                ge = gq.pop_front();
                chk("gnt", int'(gnt), int'(ge[5:2]));
                chk("nand_a", int'(nand_a), int'(ge[1]));
                chk("nand_b", int'(nand_b), int'(ge[0]));
            end else begin
                chk("idle_gnt_operands", int'({gnt, nand_a, nand_b}), 0);
            end
            if (rq.size() > 0 && rq[0][26:11] == cyc[15:0]) begin
                re = rq.pop_front();
                chk("y_valid", int'(y_valid), 1);
                chk("y", int'(y), int'(re[10]));
                chk("y_id", int'(y_id), int'(re[9:8]));
                chk("ops_done", int'(ops_done), int'(re[7:0]));
                last_y = re[10];
                last_id = re[9:8];
                last_ops = re[7:0];
            end else begin
                chk("y_valid_idle", int'(y_valid), 0);
                chk("result_hold", int'({y, y_id, ops_done}), int'({last_y, last_id, last_ops}));
            end
            chk("gnt_yvalid_overlap", int'((|gnt) && y_valid), 0);
        end
    end

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clk);
            if (req == '0 && gnt == '0 && gq.size() == 0 && rq.size() == 0 &&
                opq[0].size() == 0 && opq[1].size() == 0 &&
                opq[2].size() == 0 && opq[3].size() == 0)
                done = 1'b1;
        end
        chk("idle_reached", int'(done), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        // reset values
        repeat (2) @(negedge clk);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_nand", int'({nand_a, nand_b}), 0);
        chk("rst_y", int'({y, y_id}), 0);
        chk("rst_y_valid", int'(y_valid), 0);
        chk("rst_ops_done", int'(ops_done), 0);
        rst = 1'b0;
        @(negedge clk);

        // single request on requester 1 with a=b=1
        opq[1].push_back(2'b11);
        wait_idle(50);

        // truth table through requester 0
        opq[0].push_back(2'b00);
        opq[0].push_back(2'b01);
        opq[0].push_back(2'b10);
        opq[0].push_back(2'b11);
        wait_idle(50);

        // fairness: everyone keeps requesting
        for (int k = 0; k < 5; k++)
            for (int i = 0; i < NREQ; i++)
                opq[i].push_back(2'($urandom_range(0, 3)));
        wait_idle(200);

        // pointer skip: grant 1, then req = 1001 must go 3 then 0
        opq[1].push_back(2'b10);
        wait_idle(50);
        opq[0].push_back(2'b11);
        opq[3].push_back(2'b01);
        wait_idle(50);

        // counter wrap: 260 back-to-back operations on one requester
        for (int k = 0; k < 260; k++) opq[2].push_back(2'($urandom_range(0, 3)));
        wait_idle(1000);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            int r;
            @(negedge clk);
            r = $urandom_range(0, NREQ - 1);
            if ($urandom_range(0, 3) != 0 && opq[r].size() < 2)
                opq[r].push_back(2'($urandom_range(0, 3)));
        end
        wait_idle(1000);

        // reset asserted during the grant cycle of an operation
        opq[3].push_back(2'b11);
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            if (gnt[3]) begin
                rst = 1'b1;
                seen = 1'b1;
            end
        end
        chk("mid_op_grant_seen", int'(seen), 1);
        #1;
        chk("mid_rst_gnt", int'(gnt), 0);
        chk("mid_rst_nand", int'({nand_a, nand_b}), 0);
        chk("mid_rst_y_valid", int'(y_valid), 0);
        chk("mid_rst_ops_done", int'(ops_done), 0);
        repeat (3) @(negedge clk);
        opq[1].push_back(2'b01);
        opq[2].push_back(2'b10);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (gnt != '0) begin
                seen = 1'b1;
                chk("post_reset_first_grant", int'(gnt), 2);
            end
        end
        chk("post_reset_grant_seen", int'(seen), 1);
        wait_idle(100);

        chk("grant_queue_drained", gq.size(), 0);
        chk("result_queue_drained", rq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nand_share_arbiter.md
# nand_share_arbiter

Round-robin arbiter and sequencer that shares the single 2-input NAND cell among up to NREQ requesters. It accepts per-requester operand pairs with a request/grant handshake and drives the winning pair onto the shared NAND inputs. It then captures the NAND output into a result register tagged with the requester index. It sits between the user-logic requesters and the NAND datapath and owns all access to that cell.

## Interface
- NREQ, default 4: number of requesters; power of two, 2..8.
- IDW, default $clog2(NREQ): width of requester index fields.

- clk  input  1  single design clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- req  input  NREQ  per-requester request level; bit i held high while requester i has an operation pending.
- op_a  input  NREQ  operand A for each requester; must be stable while the matching req bit is high.
- op_b  input  NREQ  operand B for each requester; must be stable while the matching req bit is high.
- gnt  output  NREQ  one-hot grant; high for exactly one cycle per accepted operation.
- nand_a  output  1  operand A driven to the shared NAND cell.
- nand_b  output  1  operand B driven to the shared NAND cell.
- nand_y  input  1  combinational output of the shared NAND cell.
- y  output  1  captured NAND result.
- y_id  output  IDW  requester index that owns y.
- y_valid  output  1  one-cycle pulse: y and y_id are new.
- ops_done  output  8  count of completed operations; wraps 255 -> 0.

## Operation
- FSM has two states, IDLE and EVAL. Reset state is IDLE.
- Round-robin pointer ptr (IDW bits) resets to 0.
- IDLE with req == 0: stay in IDLE. gnt = 0, nand_a = nand_b = 0.
- IDLE with req != 0: the winner w is the first index i with req[i] = 1, searching ptr, ptr+1, ... mod NREQ. On that clock edge:
  - gnt is registered to one-hot w.
  - nand_a/nand_b are registered to op_a[w]/op_b[w].
  - w is stored as the current tag.
  - ptr is set to (w+1) mod NREQ.
  - The FSM moves to EVAL.
- EVAL: gnt, nand_a and nand_b hold for this one cycle. On the next edge:
  - y <= nand_y, y_id <= tag, y_valid <= 1, ops_done <= ops_done + 1.
  - gnt and the NAND operands return to 0.
  - The FSM returns to IDLE.
- y_valid is cleared on every edge on which no capture occurs.
- y and y_id hold their last captured values until the next capture.
- req is not sampled in EVAL. A requester must drop req, or present a new operation, by the edge that ends its gnt cycle. Registered deassertion on gnt satisfies this.
- A requester that never drops req is re-served only when its round-robin turn comes up again, so no requester starves.
- ops_done is modulo 256 and has no saturation.

## Timing
- Reset values: gnt = 0, nand_a = 0, nand_b = 0, y = 0, y_id = 0, y_valid = 0, ops_done = 0, ptr = 0, state = IDLE.
- Latency: req sampled at edge E0 -> gnt and operands valid during E0..E1 -> y_valid high during E1..E2.
- Throughput is at most one operation per 2 cycles. With continuous requests, gnt pulses at E0, E2, E4, … and y_valid pulses at E1, E3, E5, …
- gnt and y_valid are never high in the same cycle.
- Simultaneous requests are resolved by ptr only. Requester index alone gives no fixed priority.
- A req that rises during EVAL is considered at the next IDLE edge.
- rst asserted during EVAL: the operation is discarded. There is no y_valid pulse and ops_done is not incremented, and all outputs go to reset values asynchronously.
- rst deassertion takes effect at the first rising edge with rst = 0.

## Test plan
- Single request: NREQ = 4, req = 0010, op_a[1] = 1, op_b[1] = 1.
  - gnt = 0010 for one cycle with nand_a = nand_b = 1.
  - Next cycle: y_valid = 1, y = 0, y_id = 1, ops_done = 1.
- Exhaustive truth table: requester 0 issues (a,b) = 00, 01, 10, 11 in sequence. Expect y = 1, 1, 1, 0 with y_id = 0 each time, and ops_done = 4.
- Fairness: hold req = 1111 continuously, with requesters dropping and reasserting per handshake.
  - Grants follow 0001, 0010, 0100, 1000, 0001, …
  - y_valid pulses every 2 cycles with y_id = 0, 1, 2, 3, 0.
- Pointer skip: after a grant to index 1, present req = 1001. Next grant is index 3 (ptr = 2 skips to 3), then index 0.
- Counter wrap: perform 256 operations. ops_done reads 255 after the 255th and 0 after the 256th.
- Reset mid-operation: assert rst in the EVAL cycle.
  - gnt, nand_a, nand_b, y_valid and ops_done are 0 immediately.
  - No y_valid pulse follows.
  - After release, the first grant goes to the lowest requesting index (ptr = 0).
